spi_responder: RTL and testbench
================================

SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2: synchronizer depth for SPI_CLK, SPI_EN and SPI_MOSI (legal 2..3).
REQ-002 SHALL provide ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- SPI_CLK, input, 1: serial clock from the initiator; CPOL=1.
- SPI_EN, input, 1: chip select, active-low.
- SPI_MOSI, input, 1: serial data in, MSB first.
- SPI_MISO, output, 1: serial data out, MSB first.
- SPI_MISO_OE, output, 1: MISO output enable.
- tx_data, input, 8: next byte to return.
- tx_valid, input, 1: tx_data valid.
- tx_ready, output, 1: holding buffer empty.
- rx_data, output, 8: last received byte.
- rx_valid, output, 1: one-cycle strobe, rx_data new.
- rx_overrun, output, 1: sticky status.
- tx_underrun, output, 1: sticky status.
- status_clr, input, 1: clears both sticky flags.
REQ-003 SHALL use one clock (clk); reset rst_n SHALL be asynchronous and active-low.

Function
REQ-004 SHALL implement SPI mode 3 (CPOL=1, CPHA=1), 8-bit words, MSB first.
REQ-005 SHALL synchronize SPI_CLK, SPI_EN and SPI_MOSI through SYNC_STAGES flops and detect edges on the synchronized SPI_CLK.
REQ-006 SHALL require each SPI_CLK half-period to be at least SYNC_STAGES+2 clk cycles; behaviour below this rate is undefined.
REQ-007 SHALL implement FSM IDLE/ACTIVE: IDLE->ACTIVE on synchronized SPI_EN falling; ACTIVE->IDLE on SPI_EN rising; no other transitions.
REQ-008 On IDLE->ACTIVE and at each byte boundary, SHALL move the holding buffer into the TX shift register and empty the buffer; if the buffer is empty, SHALL load 8'hFF instead.
REQ-009 SHALL accept tx_data into the holding buffer on a clk edge with tx_valid && tx_ready; tx_ready SHALL be high exactly when the buffer is empty.
REQ-010 On each synchronized SPI_CLK falling edge in ACTIVE, SHALL drive SPI_MISO with TX shift register bit 7 and then shift left by one.
REQ-011 On each synchronized SPI_CLK rising edge in ACTIVE, SHALL shift the synchronized SPI_MOSI into the RX shift LSB and increment a 3-bit bit counter.
REQ-012 On the 8th rising edge, SHALL update rx_data and pulse rx_valid for one cycle, no later than 2 clk cycles after edge detection; the counter SHALL wrap to 0 for the next byte in the same frame.
REQ-013 SPI_MISO_OE SHALL be 1 only in ACTIVE; SPI_MISO SHALL be 1 when not enabled.
REQ-014 On SPI_EN rising mid-byte, SHALL discard the partial byte with no rx_valid, clear the bit counter and keep the holding buffer.
REQ-015 SPI_CLK edges while SPI_EN is high SHALL be ignored.
REQ-016 A tx accept in the same cycle as a byte-boundary load SHALL fill the buffer after the load; the loaded byte is the prior buffer content, or 8'hFF if the buffer was empty.

Reset
REQ-017 While rst_n is low, SHALL force IDLE, bit counter 0, buffer empty.
REQ-018 Reset values SHALL be: tx_ready=1, rx_data=0, rx_valid=0, SPI_MISO=1, SPI_MISO_OE=0, rx_overrun=0, tx_underrun=0; synchronizers SHALL reset to SPI_CLK=1, SPI_EN=1, SPI_MOSI=0.
REQ-019 Reset asserted mid-frame SHALL abort the frame; after release, the block SHALL wait for a fresh SPI_EN falling edge.

Configuration
REQ-020 With macro SPI_RESPONDER_STATUS_EN defined:
- rx_overrun SHALL set when a byte completes before the previous rx_valid byte is followed by status_clr.
- tx_underrun SHALL set when 8'hFF is loaded because the buffer is empty.
- status_clr SHALL clear both flags; a set and a clear in the same cycle SHALL leave the flag set.
REQ-021 Without SPI_RESPONDER_STATUS_EN, rx_overrun and tx_underrun SHALL be constant 0 and status_clr SHALL be ignored.

Verification
REQ-022 Preload tx_data=8'hA5; frame with MOSI 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; one rx_valid pulse.
REQ-023 Two-byte frame, second tx_data 8'h0F supplied while byte 1 shifts -> MISO returns A5 then 0F; two rx_valid pulses.
REQ-024 Frame with no tx_valid -> MISO all 1s (8'hFF); tx_underrun=1 when the macro is defined, 0 when it is not.
REQ-025 SPI_EN rises after 5 bits -> no rx_valid; the next frame receives 8'h81 correctly.
REQ-026 rst_n pulsed low mid-byte -> outputs at reset values, SPI_MISO_OE=0; the next frame receives 8'h5A correctly.

Source files
------------

// File: rtl/spi_responder.sv
// spi_responder: SPI mode 3 (CPOL=1, CPHA=1) byte responder, MSB first.
// SPI_CLK, SPI_EN and SPI_MOSI are sampled through SYNC_STAGES flops on clk.
// A one-byte holding buffer feeds the TX shift register at each frame start and byte boundary.
// Optional macro SPI_RESPONDER_STATUS_EN enables the sticky rx_overrun/tx_underrun flags.
module spi_responder #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SPI_CLK,
    input  logic       SPI_EN,
    input  logic       SPI_MOSI,
    output logic       SPI_MISO,
    output logic       SPI_MISO_OE,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_overrun,
    output logic       tx_underrun,
    input  logic       status_clr
);

    localparam int unsigned CNT_W  = 3;
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_en_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_sync_vld;
    logic                   r_sclk_prev;
    logic                   r_en_prev;
    logic                   r_armed;
    logic [0:0]             r_state;
    logic [0:0]             w_state_next;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [6:0]             r_rx_shift;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;
    logic [7:0]             r_tx_shift;
    logic [7:0]             r_buf;
    logic                   r_tx_ready;
    logic                   r_miso;
    logic                   r_miso_oe;

    logic w_sclk;
    logic w_en;
    logic w_mosi;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_en_fall;
    logic w_en_rise;
    logic w_active;
    logic w_byte_done;
    logic w_load;
    logic w_accept;

    // Input synchronizers; r_sync_vld marks when the pipes hold real input samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '1;
            r_en_sync   <= '1;
            r_mosi_sync <= '0;
            r_sync_vld  <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SPI_CLK};
            r_en_sync   <= {r_en_sync[SYNC_STAGES-2:0], SPI_EN};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            r_sync_vld  <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_en   = r_en_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // Edge history; a frame may only start after SPI_EN has been seen deasserted since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_prev <= 1'b1;
            r_en_prev   <= 1'b1;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_prev <= w_sclk;
            r_en_prev   <= w_en;
            r_armed     <= r_armed | (r_sync_vld[SYNC_STAGES-1] & w_en);
        end
    end

    assign w_sclk_rise = ~r_sclk_prev & w_sclk;
    assign w_sclk_fall = r_sclk_prev & ~w_sclk;
    assign w_en_fall   = r_armed & r_en_prev & ~w_en;
    assign w_en_rise   = ~r_en_prev & w_en;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_en_fall) w_state_next = ST_ACTIVE;
            ST_ACTIVE: if (w_en_rise) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    assign w_active    = (r_state == ST_ACTIVE) && !w_en_rise;
    assign w_byte_done = w_active && w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_load      = ((r_state == ST_IDLE) && w_en_fall) || w_byte_done;
    assign w_accept    = tx_valid && r_tx_ready;

    // Holding buffer and TX shift register; an accept in a load cycle refills after the load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf      <= 8'h00;
            r_tx_ready <= 1'b1;
            r_tx_shift <= 8'hFF;
        end else begin
            if (w_accept) begin
                r_buf      <= tx_data;
                r_tx_ready <= 1'b0;
            end else if (w_load) begin
                r_tx_ready <= 1'b1;
            end
            if (w_load) begin
                r_tx_shift <= r_tx_ready ? 8'hFF : r_buf;
            end else if (w_active && w_sclk_fall) begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b1};
            end
        end
    end

    // MISO driver: next bit on each SPI_CLK fall, idle high whenever not selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miso    <= 1'b1;
            r_miso_oe <= 1'b0;
        end else begin
            r_miso_oe <= (w_state_next == ST_ACTIVE);
            if (w_state_next != ST_ACTIVE) begin
                r_miso <= 1'b1;
            end else if (w_active && w_sclk_fall) begin
                r_miso <= r_tx_shift[7];
            end
        end
    end

    // RX shift and bit counter; a deselect mid-byte drops the partial byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if ((r_state == ST_ACTIVE) && w_en_rise) begin
                r_bit_cnt <= '0;
            end else if (w_active && w_sclk_rise) begin
                r_rx_shift <= {r_rx_shift[5:0], w_mosi};
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_rx_data  <= {r_rx_shift, w_mosi};
                    r_rx_valid <= 1'b1;
                end
            end
        end
    end

    assign SPI_MISO    = r_miso;
    assign SPI_MISO_OE = r_miso_oe;
    assign tx_ready    = r_tx_ready;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;

`ifdef SPI_RESPONDER_STATUS_EN
    logic r_rx_pending;
    logic r_rx_overrun;
    logic r_tx_underrun;

    // Sticky status; status_clr acknowledges the last byte, and a set beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_pending  <= 1'b0;
            r_rx_overrun  <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            if (w_byte_done) begin
                r_rx_pending <= 1'b1;
            end else if (status_clr) begin
                r_rx_pending <= 1'b0;
            end
            if (w_byte_done && r_rx_pending) begin
                r_rx_overrun <= 1'b1;
            end else if (status_clr) begin
                r_rx_overrun <= 1'b0;
            end
            if (w_load && r_tx_ready) begin
                r_tx_underrun <= 1'b1;
            end else if (status_clr) begin
                r_tx_underrun <= 1'b0;
            end
        end
    end

    assign rx_overrun  = r_rx_overrun;
    assign tx_underrun = r_tx_underrun;
`else
    logic w_unused_status;
    assign w_unused_status = status_clr;
    assign rx_overrun      = 1'b0;
    assign tx_underrun     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: mode-3 frames driven at 8 clk per SPI half-period.
module tb_spi_responder;

    localparam int unsigned HALF = 8;
`ifdef SPI_RESPONDER_STATUS_EN
    localparam logic [7:0] STAT = 8'd1;
`else
    localparam logic [7:0] STAT = 8'd0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SPI_CLK;
    logic       SPI_EN;
    logic       SPI_MOSI;
    logic       SPI_MISO;
    logic       SPI_MISO_OE;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_overrun;
    logic       tx_underrun;
    logic       status_clr;

    int n_checks = 0;
    int n_errors = 0;
    int rx_pulses = 0;

    spi_responder #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .SPI_CLK(SPI_CLK), .SPI_EN(SPI_EN), .SPI_MOSI(SPI_MOSI),
        .SPI_MISO(SPI_MISO), .SPI_MISO_OE(SPI_MISO_OE),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_overrun(rx_overrun), .tx_underrun(tx_underrun),
        .status_clr(status_clr)
    );

    always #5 clk = ~clk;

    // Count clk cycles with rx_valid high, sampled away from the active edge.
    always @(negedge clk) if (rx_valid) rx_pulses = rx_pulses + 1;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic clear_status();
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
    endtask

    // Shift nbits MSB first; MISO is captured just before each rising SPI_CLK.
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            SPI_CLK  = 1'b0;
            SPI_MOSI = mo[7-i];
            wait_clk(HALF);
            mi      = {mi[6:0], SPI_MISO};
            SPI_CLK = 1'b1;
            wait_clk(HALF);
        end
    endtask

    logic [7:0] miso_b;
    int         base;

    initial begin
        rst_n = 1'b0; SPI_CLK = 1'b1; SPI_EN = 1'b1; SPI_MOSI = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; status_clr = 1'b0;
        wait_clk(3);
        check("rst_tx_ready", 8'(tx_ready), 8'd1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", 8'(rx_valid), 8'd0);
        check("rst_miso", 8'(SPI_MISO), 8'd1);
        check("rst_oe", 8'(SPI_MISO_OE), 8'd0);
        check("rst_overrun", 8'(rx_overrun), 8'd0);
        check("rst_underrun", 8'(tx_underrun), 8'd0);
        rst_n = 1'b1;
        wait_clk(6);

        // Single byte: A5 out, 3C in.
        push(8'hA5);
        check("t1_buf_full", 8'(tx_ready), 8'd0);
        base = rx_pulses;
        SPI_EN = 1'b0; wait_clk(HALF);
        check("t1_oe_on", 8'(SPI_MISO_OE), 8'd1);
        check("t1_buf_loaded", 8'(tx_ready), 8'd1);
        spi_xfer(8'h3C, 8, miso_b);
        SPI_EN = 1'b1; wait_clk(HALF);
        check("t1_miso", miso_b, 8'hA5);
        check("t1_rx_data", rx_data, 8'h3C);
        check("t1_pulses", 8'(rx_pulses - base), 8'd1);
        check("t1_oe_off", 8'(SPI_MISO_OE), 8'd0);
        check("t1_miso_idle", 8'(SPI_MISO), 8'd1);
        check("t1_overrun", 8'(rx_overrun), 8'd0);
        check("t1_underrun", 8'(tx_underrun), STAT);
        clear_status();
        check("t1_clr_underrun", 8'(tx_underrun), 8'd0);

        // Two bytes, second TX byte supplied while the first is in the shifter.
        push(8'hA5);
        base = rx_pulses;
        SPI_EN = 1'b0; wait_clk(HALF);
        push(8'h0F);
        check("t2_buf_full", 8'(tx_ready), 8'd0);
        spi_xfer(8'h12, 8, miso_b);
        check("t2_miso0", miso_b, 8'hA5);
        check("t2_rx0", rx_data, 8'h12);
        spi_xfer(8'hC3, 8, miso_b);
        SPI_EN = 1'b1; wait_clk(HALF);
        check("t2_miso1", miso_b, 8'h0F);
        check("t2_rx1", rx_data, 8'hC3);
        check("t2_pulses", 8'(rx_pulses - base), 8'd2);
        check("t2_overrun", 8'(rx_overrun), STAT);
        check("t2_underrun", 8'(tx_underrun), STAT);
        clear_status();
        check("t2_clr_overrun", 8'(rx_overrun), 8'd0);
        check("t2_clr_underrun", 8'(tx_underrun), 8'd0);

        // No TX data: responder returns FF.
        base = rx_pulses;
        SPI_EN = 1'b0; wait_clk(HALF);
        spi_xfer(8'h00, 8, miso_b);
        SPI_EN = 1'b1; wait_clk(HALF);
        check("t3_miso", miso_b, 8'hFF);
        check("t3_rx_data", rx_data, 8'h00);
        check("t3_pulses", 8'(rx_pulses - base), 8'd1);
        check("t3_overrun", 8'(rx_overrun), 8'd0);
        check("t3_underrun", 8'(tx_underrun), STAT);
        clear_status();

        // Deselect after 5 bits: no byte, buffer retained for the next frame.
        base = rx_pulses;
        SPI_EN = 1'b0; wait_clk(HALF);
        push(8'h66);
        spi_xfer(8'hF0, 5, miso_b);
        SPI_EN = 1'b1; wait_clk(HALF);
        check("t4_no_pulse", 8'(rx_pulses - base), 8'd0);
        check("t4_rx_hold", rx_data, 8'h00);
        check("t4_buf_kept", 8'(tx_ready), 8'd0);
        base = rx_pulses;
        SPI_EN = 1'b0; wait_clk(HALF);
        spi_xfer(8'h81, 8, miso_b);
        SPI_EN = 1'b1; wait_clk(HALF);
        check("t4_miso", miso_b, 8'h66);
        check("t4_rx_data", rx_data, 8'h81);
        check("t4_pulses", 8'(rx_pulses - base), 8'd1);
        clear_status();

        // Reset mid-byte; SPI_EN stays low across release and must not restart the frame.
        push(8'h44);
        SPI_EN = 1'b0; wait_clk(HALF);
        spi_xfer(8'hE0, 3, miso_b);
        SPI_CLK = 1'b0; wait_clk(2);
        rst_n = 1'b0; wait_clk(2);
        check("t5_rst_miso", 8'(SPI_MISO), 8'd1);
        check("t5_rst_oe", 8'(SPI_MISO_OE), 8'd0);
        check("t5_rst_tx_ready", 8'(tx_ready), 8'd1);
        check("t5_rst_rx_data", rx_data, 8'h00);
        check("t5_rst_rx_valid", 8'(rx_valid), 8'd0);
        SPI_CLK = 1'b1;
        rst_n = 1'b1; wait_clk(10);
        check("t5_no_restart", 8'(SPI_MISO_OE), 8'd0);
        SPI_EN = 1'b1; wait_clk(HALF);
        push(8'h96);
        base = rx_pulses;
        SPI_EN = 1'b0; wait_clk(HALF);
        spi_xfer(8'h5A, 8, miso_b);
        SPI_EN = 1'b1; wait_clk(HALF);
        check("t5_miso", miso_b, 8'h96);
        check("t5_rx_data", rx_data, 8'h5A);
        check("t5_pulses", 8'(rx_pulses - base), 8'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
